f_npc_redirect: RTL and testbench

// - F-stage PC register and next-PC unit; consumes the D-stage branch decision (cmp_result/btype)
//   and jump info; drives the instruction-fetch address.
// - MIPS-style delay slot: a redirect from D takes effect on the PC after the delay-slot fetch.
// - Latches a redirect that arrives while fetch is held (imem not ready) and applies it on the next advance.

---
 rtl/f_npc_redirect_pkg.sv | 32 +++
 rtl/f_npc_redirect_calc.sv | 35 +++
 rtl/f_npc_redirect.sv | 102 ++++++++++
 tb/tb_f_npc_redirect.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/f_npc_redirect_pkg.sv
// Shared encodings and address constants for the F-stage next-PC unit.
// PC_MIN/PC_MAX are only consumed when NPC_ALIGN_CHECK_EN is defined.
package f_npc_redirect_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] PC_MIN   = 32'h0000_3000;
  localparam logic [31:0] PC_MAX   = 32'h0000_6ffc;

  typedef enum logic [2:0] {
    BT_NONE = 3'b000,
    BT_BEQ  = 3'b001,
    BT_BNE  = 3'b010,
    BT_BLEZ = 3'b011,
    BT_BGTZ = 3'b100,
    BT_BLTA = 3'b101,
    BT_BGEZ = 3'b110,
    BT_BLTZ = 3'b111
  } btype_e;

  typedef enum logic [1:0] {
    JT_NONE = 2'b00,
    JT_J    = 2'b01,
    JT_JR   = 2'b10,
    JT_RSV  = 2'b11
  } jtype_e;

  typedef enum logic {
    S_SEQ  = 1'b0,
    S_PEND = 1'b1
  } npc_state_e;

endpackage

// File: rtl/f_npc_redirect_calc.sv
// Combinational redirect decision and target for the D-stage instruction.
// A jump wins over a branch; the reserved jtype code behaves as a register jump.
module f_npc_calc
  import f_npc_redirect_pkg::*;
(
  input  logic        d_valid,
  input  logic        stall,
  input  logic [2:0]  d_btype,
  input  logic        d_cmp_result,
  input  logic [1:0]  d_jtype,
  input  logic [31:0] d_pc,
  input  logic [15:0] d_imm16,
  input  logic [25:0] d_instr_index,
  input  logic [31:0] d_rs_val,
  output logic        taken,
  output logic [31:0] target
);

  logic        req;
  logic [31:0] br_off;

  assign req    = (d_btype != BT_NONE && d_cmp_result) || d_jtype != JT_NONE;
  assign taken  = d_valid && !stall && req;
  assign br_off = {{14{d_imm16[15]}}, d_imm16, 2'b00};

  always_comb begin
    target = d_pc + 32'd4 + br_off;
    if (d_jtype == JT_J) begin
      target = {d_pc[31:28], d_instr_index, 2'b00};
    end else if (d_jtype != JT_NONE) begin
      target = d_rs_val;
    end
  end

endmodule

// File: rtl/f_npc_redirect.sv
// F-stage PC register with delay-slot redirect and held-redirect latching.
// Build option NPC_ALIGN_CHECK_EN adds the registered fetch address-error flag.
//
// state  | meaning
// S_SEQ  | no redirect outstanding; PC advances by 4 or to a fresh target
// S_PEND | redirect latched while fetch was held; applied on next advance
module f_npc_redirect
  import f_npc_redirect_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        d_valid,
  input  logic [2:0]  d_btype,
  input  logic        d_cmp_result,
  input  logic [1:0]  d_jtype,
  input  logic [31:0] d_pc,
  input  logic [15:0] d_imm16,
  input  logic [25:0] d_instr_index,
  input  logic [31:0] d_rs_val,
  output logic [31:0] f_pc,
  output logic        f_req,
  output logic        redirect_pend,
  output logic        f_exc_adel
);

  npc_state_e  state;
  logic [31:0] pend_target;
  logic [31:0] pc_next;
  logic        taken;
  logic [31:0] target;
  logic        advance;

  f_npc_calc u_calc (
    .d_valid       (d_valid),
    .stall         (stall),
    .d_btype       (d_btype),
    .d_cmp_result  (d_cmp_result),
    .d_jtype       (d_jtype),
    .d_pc          (d_pc),
    .d_imm16       (d_imm16),
    .d_instr_index (d_instr_index),
    .d_rs_val      (d_rs_val),
    .taken         (taken),
    .target        (target)
  );

  assign advance = f_req && imem_ready && !stall;

  always_comb begin
    pc_next = f_pc;
    if (advance) begin
      if (state == S_PEND) pc_next = pend_target;
      else if (taken)      pc_next = target;
      else                 pc_next = f_pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_SEQ;
      f_pc          <= RESET_PC;
      f_req         <= 1'b0;
      redirect_pend <= 1'b0;
      pend_target   <= '0;
    end else begin
      f_req <= 1'b1;
      f_pc  <= pc_next;
      case (state)
        S_SEQ: begin
          // Held fetch: keep the target until the delay slot is accepted.
          if (!advance && taken) begin
            pend_target   <= target;
            state         <= S_PEND;
            redirect_pend <= 1'b1;
          end
        end
        S_PEND: begin
          if (advance) begin
            state         <= S_SEQ;
            redirect_pend <= 1'b0;
          end
        end
        default: begin
          state         <= S_SEQ;
          redirect_pend <= 1'b0;
        end
      endcase
    end
  end

`ifdef NPC_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) f_exc_adel <= 1'b0;
    else       f_exc_adel <= (pc_next[1:0] != 2'b00) || (pc_next < PC_MIN) || (pc_next > PC_MAX);
  end
`else
  assign f_exc_adel = 1'b0;
`endif

endmodule

// File: tb/tb_f_npc_redirect.sv
// Self-checking bench for f_npc_redirect: directed literal checks plus random traffic
// compared every cycle against a queue-based reference model.
module tb_f_npc_redirect;
  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset, stall, imem_ready, d_valid, d_cmp_result;
  logic [2:0]  d_btype;
  logic [1:0]  d_jtype;
  logic [31:0] d_pc, d_rs_val;
  logic [15:0] d_imm16;
  logic [25:0] d_instr_index;
  logic [31:0] f_pc;
  logic        f_req, redirect_pend, f_exc_adel;

  int checks = 0;
  int failures = 0;

  f_npc_redirect dut (
    .clk(clk), .reset(reset), .stall(stall), .imem_ready(imem_ready),
    .d_valid(d_valid), .d_btype(d_btype), .d_cmp_result(d_cmp_result),
    .d_jtype(d_jtype), .d_pc(d_pc), .d_imm16(d_imm16),
    .d_instr_index(d_instr_index), .d_rs_val(d_rs_val),
    .f_pc(f_pc), .f_req(f_req), .redirect_pend(redirect_pend), .f_exc_adel(f_exc_adel)
  );

  always #5 clk = ~clk;

  // Reference model: PC, request flag, and a queue holding at most one held target.
  logic [31:0] m_pc;
  logic        m_req;
  logic        m_exc;
  logic        m_valid = 1'b0;
  logic [31:0] m_q[$];

  function automatic logic [31:0] ref_target();
    if (d_jtype == 2'd1) return {d_pc[31:28], d_instr_index, 2'b00};
    if (d_jtype != 2'd0) return d_rs_val;
    return d_pc + 32'd4 + 32'($signed(d_imm16)) * 32'd4;
  endfunction

  function automatic logic ref_exc(input logic [31:0] pc);
`ifdef NPC_ALIGN_CHECK_EN
    return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6ffc);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_pc = RST_PC; m_req = 1'b0; m_exc = 1'b0; m_q.delete(); m_valid = 1'b1;
    end else if (m_valid) begin
      logic tk, adv;
      logic [31:0] tg;
      tk  = d_valid && !stall && ((d_btype != 0 && d_cmp_result) || d_jtype != 0);
      tg  = ref_target();
      adv = m_req && imem_ready && !stall;
      if (m_q.size() > 0) begin
        if (adv) m_pc = m_q.pop_front();
      end else if (adv) begin
        m_pc = tk ? tg : m_pc + 32'd4;
      end else if (tk) begin
        m_q.push_back(tg);
      end
      m_req = 1'b1;
      m_exc = ref_exc(m_pc);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if (f_pc !== m_pc || f_req !== m_req || redirect_pend !== (m_q.size() != 0)
          || f_exc_adel !== m_exc) begin
        failures++;
        $display("FAIL model t=%0t f_pc=%h/%h f_req=%b/%b pend=%b/%b exc=%b/%b (actual/required)",
                 $time, f_pc, m_pc, f_req, m_req, redirect_pend, (m_q.size() != 0), f_exc_adel, m_exc);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_valid = 1'b0; d_btype = 3'd0; d_cmp_result = 1'b0; d_jtype = 2'd0;
    d_pc = RST_PC; d_imm16 = 16'h0; d_instr_index = 26'h0; d_rs_val = 32'h0;
  endtask

  task automatic jr(input logic [31:0] rs);
    idle(); d_valid = 1'b1; d_jtype = 2'd2; d_rs_val = rs;
  endtask

  initial begin
    idle();
    reset = 1'b1; stall = 1'b0; imem_ready = 1'b1;
    cyc();
    chk("reset_pc", f_pc, RST_PC);
    chk("reset_req", f_req, 0);
    chk("reset_pend", redirect_pend, 0);
    chk("reset_exc", f_exc_adel, 0);
    cyc();
    reset = 1'b0;
    cyc(); chk("seq0", f_pc, 32'h3000); chk("req_up", f_req, 1);
    cyc(); chk("seq1", f_pc, 32'h3004);
    cyc(); chk("seq2", f_pc, 32'h3008);
    cyc(); chk("seq3", f_pc, 32'h300c);

    idle(); d_valid = 1'b1; d_btype = 3'd1; d_cmp_result = 1'b1; d_pc = 32'h3000; d_imm16 = 16'h0004;
    cyc(); chk("beq_taken", f_pc, 32'h3014);
    idle(); d_valid = 1'b1; d_btype = 3'd2; d_cmp_result = 1'b1; d_pc = 32'h3010; d_imm16 = 16'hfffe;
    cyc(); chk("bne_back", f_pc, 32'h300c);
    idle(); d_valid = 1'b1; d_btype = 3'd1; d_cmp_result = 1'b0; d_pc = 32'h3010; d_imm16 = 16'h0040;
    cyc(); chk("beq_not_taken", f_pc, 32'h3010);
    jr(32'h3100);
    cyc(); chk("jr", f_pc, 32'h3100);
    jr(32'h3400); stall = 1'b1;
    cyc(); chk("stall_pc", f_pc, 32'h3100); chk("stall_pend", redirect_pend, 0);
    stall = 1'b0;

    idle(); imem_ready = 1'b0; d_valid = 1'b1; d_jtype = 2'd1; d_instr_index = 26'h0000c80;
    cyc(); chk("held_pend", redirect_pend, 1); chk("held_pc", f_pc, 32'h3100);
    jr(32'h5000);
    cyc(); chk("held_pend2", redirect_pend, 1); chk("held_pc2", f_pc, 32'h3100);
    imem_ready = 1'b1;
    cyc(); chk("held_apply", f_pc, 32'h3200); chk("held_clear", redirect_pend, 0);
    idle();
    cyc(); chk("after_held", f_pc, 32'h3204);

    imem_ready = 1'b0; d_valid = 1'b1; d_jtype = 2'd1; d_instr_index = 26'h0000c80;
    cyc(); chk("pend_again", redirect_pend, 1);
    idle(); reset = 1'b1;
    cyc(); chk("rst_pend_pc", f_pc, RST_PC); chk("rst_pend_clr", redirect_pend, 0);
    reset = 1'b0; imem_ready = 1'b1;
    cyc(); chk("rst_pend_pc1", f_pc, RST_PC);
    cyc(); chk("rst_drop", f_pc, 32'h3004);

    jr(32'h3002);
    cyc(); chk("adel_misalign", f_exc_adel, `ifdef NPC_ALIGN_CHECK_EN 1 `else 0 `endif);
    jr(32'h7000);
    cyc(); chk("adel_high", f_exc_adel, `ifdef NPC_ALIGN_CHECK_EN 1 `else 0 `endif);
    jr(32'h3004);
    cyc(); chk("adel_ok", f_exc_adel, 0);
    jr(32'hffff_fffc);
    cyc(); chk("wrap_pre", f_pc, 32'hffff_fffc);
    idle();
    cyc(); chk("wrap", f_pc, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 99) == 0);
      stall      = ($urandom_range(0, 5) == 0);
      imem_ready = ($urandom_range(0, 3) != 0);
      d_valid    = ($urandom_range(0, 3) != 0);
      d_btype    = 3'($urandom_range(0, 7));
      d_cmp_result = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        4:       d_jtype = 2'd1;
        5:       d_jtype = 2'd2;
        default: d_jtype = 2'd0;
      endcase
      d_pc = ($urandom_range(0, 15) == 0) ? 32'hffff_fff0 : 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
      d_imm16       = 16'($urandom);
      d_instr_index = 26'($urandom);
      d_rs_val      = ($urandom_range(0, 1) == 1) ? 32'h3000 + 32'($urandom_range(0, 16383)) : $urandom;
      cyc();
    end
    reset = 1'b0; idle();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
